// File: rtl/duty_calc_pkg.sv
// Shared constants and state encoding for the duty-cycle calculator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package duty_calc_pkg;
    localparam int CNT_W   = 32;
    localparam int SCALE   = 1000;
    localparam int SCALE_W = 10;
    localparam int NUM_W   = CNT_W + SCALE_W + 1;
    localparam int SUM_W   = CNT_W + 1;
    localparam int DUTY_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_e;
endpackage

// File: rtl/duty_calc_if.sv
// Bundles the count-pair input strobe and the duty result outputs.
// Latency: n/a (wiring only).
// Backpressure: none; producer strobes, consumer queues one pending sample.
interface duty_calc_if;
    import duty_calc_pkg::*;

    logic              in_valid;
    logic [CNT_W-1:0]  cnt_high;
    logic [CNT_W-1:0]  cnt_low;
    logic [DUTY_W-1:0] duty;
    logic              duty_valid;
    logic              busy;
    logic              zero_err;
    logic              overrun;

    modport master (
        output in_valid, cnt_high, cnt_low,
        input  duty, duty_valid, busy, zero_err, overrun
    );

    modport slave (
        input  in_valid, cnt_high, cnt_low,
        output duty, duty_valid, busy, zero_err, overrun
    );
endinterface

// File: rtl/seq_udiv.sv
// Sequential restoring unsigned divider, one quotient bit per cycle, MSB first.
// Latency: first step is taken on the start edge; done rises NUM_W-1 edges later.
// Backpressure: none; a new start restarts the division and discards the old one.
module seq_udiv #(
    parameter int NUM_W = 43,
    parameter int DEN_W = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             done,
    output logic [NUM_W-1:0] quot,
    output logic [DEN_W-1:0] rem
);
    localparam int CW = $clog2(NUM_W + 1);

    logic [NUM_W-1:0] num_q, num_d, quot_q, quot_d, src_num, src_quot;
    logic [DEN_W-1:0] den_q, den_d, rem_q, rem_d, src_den, src_rem;
    logic [CW-1:0]    cnt_q, cnt_d, src_cnt;
    logic             run_q, run_d, done_q, done_d;
    logic [DEN_W:0]   trial, diff;
    logic             fits;

    // One restoring step; on start the step works on the fresh operands directly.
    always_comb begin
        src_num  = start ? num : num_q;
        src_den  = start ? den : den_q;
        src_rem  = start ? '0  : rem_q;
        src_quot = start ? '0  : quot_q;
        src_cnt  = start ? '0  : cnt_q;
        trial    = {src_rem, src_num[NUM_W-1]};
        fits     = trial >= {1'b0, src_den};
        diff     = trial - {1'b0, src_den};
        num_d    = num_q;
        den_d    = den_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        done_d   = done_q;
        if (start || run_q) begin
            num_d  = {src_num[NUM_W-2:0], 1'b0};
            den_d  = src_den;
            rem_d  = fits ? diff[DEN_W-1:0] : trial[DEN_W-1:0];
            quot_d = {src_quot[NUM_W-2:0], fits};
            cnt_d  = src_cnt + 1'b1;
            run_d  = (cnt_d != CW'(NUM_W));
            done_d = (cnt_d == CW'(NUM_W));
        end
    end

    // Divider state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            num_q  <= '0;
            den_q  <= '0;
            rem_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            num_q  <= num_d;
            den_q  <= den_d;
            rem_q  <= rem_d;
            quot_q <= quot_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign quot = quot_q;
    assign rem  = rem_q;
endmodule

// File: rtl/duty_calc.sv
// Duty cycle in 0.1 % units: round(SCALE * high / (high + low)), clamped to SCALE.
// Latency: in_valid edge to duty_valid is NUM_W+1 cycles, independent of operands.
// Backpressure: one-deep pending slot while busy; overwrite of a full slot pulses overrun.
module duty_calc
    import duty_calc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    duty_calc_if.slave  bus
);
    state_e             state_q, state_d;
    logic               pend_vld_q, pend_vld_d;
    logic [CNT_W-1:0]   pend_high_q, pend_high_d, pend_low_q, pend_low_d;
    logic               zero_q, zero_d;
    logic [DUTY_W-1:0]  duty_q, duty_d;
    logic               duty_valid_q, duty_valid_d;
    logic               busy_q, busy_d;
    logic               zero_err_q, zero_err_d;
    logic               overrun_q, overrun_d;

    logic               launch;
    logic [CNT_W-1:0]   src_high, src_low;
    logic [SUM_W-1:0]   sum;
    logic [NUM_W-1:0]   num;
    logic [DUTY_W-1:0]  result;
    logic               div_done;
    logic [NUM_W-1:0]   div_quot;

    // Operand prep, FSM next state, pending slot and output flags.
    always_comb begin
        launch   = ((state_q == IDLE) || (state_q == DONE)) && (pend_vld_q || bus.in_valid);
        src_high = pend_vld_q ? pend_high_q : bus.cnt_high;
        src_low  = pend_vld_q ? pend_low_q  : bus.cnt_low;
        sum      = {1'b0, src_high} + {1'b0, src_low};
        num      = NUM_W'(src_high) * NUM_W'(SCALE) + NUM_W'(sum >> 1);
        if (zero_q)
            result = '0;
        else if (div_quot > NUM_W'(SCALE))
            result = DUTY_W'(SCALE);
        else
            result = div_quot[DUTY_W-1:0];

        state_d      = state_q;
        pend_vld_d   = pend_vld_q;
        pend_high_d  = pend_high_q;
        pend_low_d   = pend_low_q;
        zero_d       = zero_q;
        duty_d       = duty_q;
        duty_valid_d = 1'b0;
        busy_d       = busy_q;
        zero_err_d   = zero_err_q;
        overrun_d    = 1'b0;

        case (state_q)
            IDLE: ;
            DIV: begin
                if (div_done)
                    state_d = DONE;
            end
            DONE: begin
                duty_d       = result;
                duty_valid_d = 1'b1;
                zero_err_d   = zero_q;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A launch (from IDLE or straight out of DONE) takes priority over going idle.
        if (launch) begin
            state_d = DIV;
            busy_d  = 1'b1;
            zero_d  = (sum == '0);
        end

        // An input consumed directly by a launch never touches the pending slot.
        if (bus.in_valid) begin
            if (!(launch && !pend_vld_q)) begin
                pend_vld_d  = 1'b1;
                pend_high_d = bus.cnt_high;
                pend_low_d  = bus.cnt_low;
                overrun_d   = pend_vld_q && !launch;
            end
        end else if (launch) begin
            pend_vld_d = 1'b0;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pend_vld_q   <= 1'b0;
            pend_high_q  <= '0;
            pend_low_q   <= '0;
            zero_q       <= 1'b0;
            duty_q       <= '0;
            duty_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            zero_err_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_vld_q   <= pend_vld_d;
            pend_high_q  <= pend_high_d;
            pend_low_q   <= pend_low_d;
            zero_q       <= zero_d;
            duty_q       <= duty_d;
            duty_valid_q <= duty_valid_d;
            busy_q       <= busy_d;
            zero_err_q   <= zero_err_d;
            overrun_q    <= overrun_d;
        end
    end

    seq_udiv #(
        .NUM_W (NUM_W),
        .DEN_W (SUM_W)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (launch),
        .num   (num),
        .den   (sum),
        .done  (div_done),
        .quot  (div_quot),
        .rem   ()
    );

    assign bus.duty       = duty_q;
    assign bus.duty_valid = duty_valid_q;
    assign bus.busy       = busy_q;
    assign bus.zero_err   = zero_err_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_duty_calc.sv
// Self-checking bench for duty_calc: directed vectors, random vectors, corner sequences.
// Latency: expects duty_valid exactly 44 edges after the in_valid edge.
// Backpressure: exercises the pending slot, overrun and reset mid-division.
module tb_duty_calc;
    logic clk;
    logic rst;
    int   cyc;
    int   n_pass;
    int   n_total;

    duty_calc_if bus ();

    duty_calc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] h;
        logic [31:0] l;
        logic [15:0] d;
        logic        z;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: plain arithmetic straight from the duty definition.
    function automatic int ref_duty(input longint unsigned h, input longint unsigned l);
        longint unsigned s, q;
        s = h + l;
        if (s == 0) return 0;
        q = (h * 1000 + s / 2) / s;
        if (q > 1000) q = 1000;
        return int'(q);
    endfunction

    // Called at a negedge; the following posedge samples the strobe.
    task automatic pulse(input logic [31:0] h, input logic [31:0] l);
        bus.in_valid = 1'b1;
        bus.cnt_high = h;
        bus.cnt_low  = l;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic run_one(input logic [31:0] h, input logic [31:0] l,
                           input int exp_d, input logic exp_z, input string tag);
        int e0, lat, busy_bad;
        bit got;
        pulse(h, l);
        e0 = cyc;
        got = 0;
        busy_bad = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (bus.duty_valid) got = 1;
            else if (!bus.busy) busy_bad++;
        end
        lat = got ? (cyc - e0) : -1;
        check($sformatf("%s_latency", tag), lat, 44);
        check($sformatf("%s_duty", tag), bus.duty, exp_d);
        check($sformatf("%s_zero_err", tag), bus.zero_err, exp_z);
        check($sformatf("%s_busy_during", tag), busy_bad + (bus.busy ? 1 : 0), 0);
        @(negedge clk);
        check($sformatf("%s_valid_width", tag), bus.duty_valid, 0);
    endtask

    initial begin
        int e0, nres, seen;
        logic [31:0] rh, rl;
        vecs[0] = '{32'd100, 32'd300, 16'd250, 1'b0};
        vecs[1] = '{32'd1, 32'd2, 16'd333, 1'b0};
        vecs[2] = '{32'd2, 32'd1, 16'd667, 1'b0};
        vecs[3] = '{32'd1, 32'd1999, 16'd1, 1'b0};
        vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd500, 1'b0};
        vecs[5] = '{32'hFFFF_FFFF, 32'd0, 16'd1000, 1'b0};
        vecs[6] = '{32'd0, 32'hFFFF_FFFF, 16'd0, 1'b0};
        vecs[7] = '{32'd0, 32'd0, 16'd0, 1'b1};
        vecs[8] = '{32'd5, 32'd5, 16'd500, 1'b0};

        cyc = 0;
        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.cnt_high = '0;
        bus.cnt_low  = '0;
        repeat (3) @(negedge clk);
        check("rst_duty", bus.duty, 0);
        check("rst_duty_valid", bus.duty_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_zero_err", bus.zero_err, 0);
        check("rst_overrun", bus.overrun, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table, including rounding, extremes and divide-by-zero.
        for (int i = 0; i < 9; i++)
            run_one(vecs[i].h, vecs[i].l, int'(vecs[i].d), vecs[i].z, $sformatf("vec%0d", i));

        // Random operands against the arithmetic reference.
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 3))
                0: begin rh = $urandom_range(0, 20); rl = $urandom_range(0, 20); end
                1: begin rh = $urandom;              rl = $urandom;              end
                2: begin rh = $urandom;              rl = $urandom_range(0, 20); end
                default: begin rh = $urandom_range(0, 20); rl = $urandom;        end
            endcase
            run_one(rh, rl, ref_duty(longint'(rh), longint'(rl)), (rh == 0 && rl == 0),
                    $sformatf("rnd%0d", i));
        end

        // Pending slot: E0 launch, E5 queued, E9 overwrites and flags overrun.
        pulse(32'd10, 32'd30);
        e0 = cyc;
        repeat (4) @(negedge clk);
        pulse(32'd1, 32'd1);
        check("bp_first_pend_no_overrun", bus.overrun, 0);
        repeat (3) @(negedge clk);
        pulse(32'd3, 32'd1);
        check("bp_overrun_at_e9", (cyc - e0) * 2 + (bus.overrun ? 1 : 0), 19);
        @(negedge clk);
        check("bp_overrun_width", bus.overrun, 0);
        nres = 0;
        while (cyc < e0 + 110) begin
            @(negedge clk);
            if (bus.duty_valid) begin
                if (nres == 0) begin
                    check("bp_res0_cycle", cyc - e0, 44);
                    check("bp_res0_duty", bus.duty, 250);
                    check("bp_res0_busy_relaunch", bus.busy, 1);
                end else if (nres == 1) begin
                    check("bp_res1_cycle", cyc - e0, 88);
                    check("bp_res1_duty", bus.duty, 750);
                end
                nres++;
            end
        end
        check("bp_result_count", nres, 2);

        // Reset in the middle of a division discards it entirely.
        pulse(32'd1, 32'd3);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_duty", bus.duty, 0);
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.duty_valid) seen++;
        end
        check("mid_rst_no_result", seen, 0);
        run_one(32'd3, 32'd1, 750, 1'b0, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
